inst_decode: RTL
================

INST_DECODE -- requirements
Module: inst_decode

Interface
REQ-001 Parameter PC_WIDTH, default 30, word-address width of in_pc, out_pc and out_branch_target.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 in_valid / in_ready  input / output  1 / 1  fetched-instruction handshake; transfer when both high on a clk edge.
REQ-005 in_instr / in_pc  input  32 / PC_WIDTH  instruction word and its word address.
REQ-006 flags_nzcv  input  4  current N,Z,C,V flags, N in bit 3.
REQ-007 flush  input  1  discard all held and incoming instructions.
REQ-008 out_valid / out_ready  output / input  1 / 1  decoded-instruction handshake to execute.
REQ-009 out_rn, out_rd, out_rm  output  4 each  register indices from [19:16], [15:12], [3:0].
REQ-010 out_alu_op  output  4  data-processing opcode [24:21].
REQ-011 out_imm  output  32  rotated immediate.
REQ-012 out_use_imm, out_set_flags, out_rf_we, out_is_branch, out_is_link, out_cond_pass, out_illegal  output  1 each  decoded control.
REQ-013 out_branch_target, out_pc  output  PC_WIDTH each  branch target and instruction address.

Function
REQ-014 Class: [27:26]=00 data-processing; [27:25]=101 branch; any other class SHALL set out_illegal=1, out_rf_we=0, out_is_branch=0.
REQ-015 Data-processing: out_use_imm=[25], out_set_flags=[20]; out_imm = zero-extended [7:0] rotated right by 2*[11:8], 0 when [25]=0.
REQ-016 Register form ([25]=0) with [11:4] nonzero SHALL set out_illegal=1 (shifts unsupported).
REQ-017 out_rf_we=1 for data-processing except opcodes 1000-1011 (TST,TEQ,CMP,CMN).
REQ-018 Branch: out_is_branch=1, out_is_link=[24], out_rf_we=0, out_branch_target = in_pc + 2 + sign-extended [23:0], modulo 2^PC_WIDTH.
REQ-019 Condition [31:28] evaluated per ARM table (EQ..AL) against flags_nzcv sampled in the accept cycle; cond 1111 -> out_cond_pass=0, out_illegal=1.
REQ-020 Decode combinational on input; result captured into a 2-entry FIFO (main + skid); outputs driven from head entry, registered.
REQ-021 States EMPTY, ONE, FULL: accept only -> +1; pop only -> -1; accept and pop -> unchanged; order preserved.
REQ-022 in_ready registered; 1 in EMPTY/ONE, 0 in FULL; throughput one instruction/cycle when out_ready held high.
REQ-023 Latency: instruction accepted at edge N appears on outputs with out_valid=1 immediately after edge N when stage was EMPTY.
REQ-024 Output payload stable while out_valid=1 and out_ready=0.
REQ-025 flush: next state EMPTY, out_valid=0, in_ready=1; an input handshake in the flush cycle is discarded; flush overrides pop and accept.

Reset
REQ-026 resetn low: state EMPTY, out_valid=0, in_ready=1, all payload outputs 0, immediately and without clk.
REQ-027 Reset mid-operation discards both entries; first handshake after release behaves as from EMPTY.

Structure
REQ-028 Shared package cpu_pkg holds ALU opcode constants, condition-code constants, class-field encodings, decoded-instruction struct.
REQ-029 Sub-module cond_eval (cond, nzcv -> pass) is instantiated once.

Verification
REQ-030 0xE2801001 at pc 0, flags 0 -> rn 0, rd 1, imm 1, alu_op 0100, use_imm 1, rf_we 1, cond_pass 1, one edge later.
REQ-031 0xE3A004FF -> imm 0xFF000000, alu_op 1101, rd 0; 0xE1500001 (CMP r0,r1) -> rf_we 0, set_flags 1, rm 1.
REQ-032 0xEAFFFFFE at pc 5 -> is_branch 1, target 5; 0xEB000003 at pc 0x3FFFFFFE -> is_link 1, target 3 (wrap).
REQ-033 0x02801001 with nzcv 0000 -> cond_pass 0; same with nzcv 0100 -> cond_pass 1; 0xF2801001 -> illegal 1.
REQ-034 out_ready=0, offer 3 instructions back-to-back -> 2 accepted, in_ready 0; out_ready=1 -> drain in order, third then accepted.
REQ-035 FULL state, assert flush (and separately resetn low mid-cycle) -> out_valid 0, in_ready 1, no stale instruction emitted.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared decode definitions: ALU opcodes, condition codes,
// instruction class fields and the decoded-instruction bundle.
package cpu_pkg;

  localparam logic [3:0] ALU_AND = 4'h0;
  localparam logic [3:0] ALU_EOR = 4'h1;
  localparam logic [3:0] ALU_SUB = 4'h2;
  localparam logic [3:0] ALU_RSB = 4'h3;
  localparam logic [3:0] ALU_ADD = 4'h4;
  localparam logic [3:0] ALU_ADC = 4'h5;
  localparam logic [3:0] ALU_SBC = 4'h6;
  localparam logic [3:0] ALU_RSC = 4'h7;
  localparam logic [3:0] ALU_TST = 4'h8;
  localparam logic [3:0] ALU_TEQ = 4'h9;
  localparam logic [3:0] ALU_CMP = 4'hA;
  localparam logic [3:0] ALU_CMN = 4'hB;
  localparam logic [3:0] ALU_ORR = 4'hC;
  localparam logic [3:0] ALU_MOV = 4'hD;
  localparam logic [3:0] ALU_BIC = 4'hE;
  localparam logic [3:0] ALU_MVN = 4'hF;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam logic [1:0] CLS_DP = 2'b00;
  localparam logic [2:0] CLS_BR = 3'b101;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_FULL
  } fifo_state_e;

  typedef struct packed {
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [3:0]  rm;
    logic [3:0]  alu_op;
    logic [31:0] imm;
    logic        use_imm;
    logic        set_flags;
    logic        rf_we;
    logic        is_branch;
    logic        is_link;
    logic        cond_pass;
    logic        illegal;
  } dec_t;

  function automatic logic [31:0] ror_imm(
    input logic [7:0] v,
    input logic [3:0] r
  );
    logic [31:0] x;
    logic [5:0]  sh;
    x  = {24'h0, v};
    sh = {1'b0, r, 1'b0};
    return (x >> sh) | (x << (6'd32 - sh));
  endfunction

  // Compare/test ops only update flags
  function automatic logic is_cmp_op(input logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/inst_decode_if.sv
// Fetch-side and execute-side handshakes of the decode stage.
// master drives instructions in and sinks decoded results.
interface inst_decode_if #(
  parameter int PC_WIDTH = 30
);
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         in_instr;
  logic [PC_WIDTH-1:0] in_pc;
  logic [3:0]          flags_nzcv;
  logic                flush;

  logic                out_valid;
  logic                out_ready;
  logic [3:0]          out_rn;
  logic [3:0]          out_rd;
  logic [3:0]          out_rm;
  logic [3:0]          out_alu_op;
  logic [31:0]         out_imm;
  logic                out_use_imm;
  logic                out_set_flags;
  logic                out_rf_we;
  logic                out_is_branch;
  logic                out_is_link;
  logic                out_cond_pass;
  logic                out_illegal;
  logic [PC_WIDTH-1:0] out_branch_target;
  logic [PC_WIDTH-1:0] out_pc;

  modport master (
    output in_valid, in_instr, in_pc,
    output flags_nzcv, flush, out_ready,
    input  in_ready, out_valid,
    input  out_rn, out_rd, out_rm, out_alu_op,
    input  out_imm, out_use_imm, out_set_flags,
    input  out_rf_we, out_is_branch, out_is_link,
    input  out_cond_pass, out_illegal,
    input  out_branch_target, out_pc
  );

  modport slave (
    input  in_valid, in_instr, in_pc,
    input  flags_nzcv, flush, out_ready,
    output in_ready, out_valid,
    output out_rn, out_rd, out_rm, out_alu_op,
    output out_imm, out_use_imm, out_set_flags,
    output out_rf_we, out_is_branch, out_is_link,
    output out_cond_pass, out_illegal,
    output out_branch_target, out_pc
  );
endinterface

// File: rtl/inst_decode_cond_eval.sv
// Condition-code check of a 4-bit cond field against NZCV.
// NV (1111) never passes.
module cond_eval
  import cpu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);
  logic n, z, c, v;

  assign n = nzcv[3];
  assign z = nzcv[2];
  assign c = nzcv[1];
  assign v = nzcv[0];

  always_comb begin
    pass = 1'b0;
    unique case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = n == v;
      COND_LT: pass = n != v;
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
    endcase
  end
endmodule

// File: rtl/inst_decode.sv
// Decode stage: combinational decode into a 2-entry
// (main + skid) FIFO, head entry drives registered outputs.
module inst_decode
  import cpu_pkg::*;
#(
  parameter int PC_WIDTH = 30
) (
  input  logic         clk,
  input  logic         resetn,
  inst_decode_if.slave bus
);
  typedef struct packed {
    dec_t                dec;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] tgt;
  } entry_t;

  fifo_state_e state_q, state_d;
  entry_t      head_q, head_d;
  entry_t      skid_q, skid_d;
  logic        in_ready_q, in_ready_d;

  logic [31:0]         instr;
  logic                is_dp;
  logic                is_br;
  logic                pass;
  logic [PC_WIDTH-1:0] off_ext;
  logic [PC_WIDTH-1:0] tgt;
  dec_t                dec;
  entry_t              new_e;
  logic                acc;
  logic                pop;

  assign instr = bus.in_instr;
  assign is_dp = instr[27:26] == CLS_DP;
  assign is_br = instr[27:25] == CLS_BR;

  cond_eval u_cond (
    .cond (instr[31:28]),
    .nzcv (bus.flags_nzcv),
    .pass (pass)
  );

  assign off_ext = {{(PC_WIDTH-24){instr[23]}}, instr[23:0]};
  assign tgt = bus.in_pc + PC_WIDTH'(2) + off_ext;

  always_comb begin
    dec           = '0;
    dec.rn        = instr[19:16];
    dec.rd        = instr[15:12];
    dec.rm        = instr[3:0];
    dec.alu_op    = instr[24:21];
    dec.cond_pass = pass;
    unique case (1'b1)
      is_dp: begin
        dec.use_imm   = instr[25];
        dec.set_flags = instr[20];
        dec.rf_we     = !is_cmp_op(instr[24:21]);
        if (instr[25]) begin
          dec.imm = ror_imm(instr[7:0], instr[11:8]);
        end else begin
          dec.illegal = |instr[11:4];
        end
      end
      is_br: begin
        dec.is_branch = 1'b1;
        dec.is_link   = instr[24];
      end
      default: dec.illegal = 1'b1;
    endcase
    if (instr[31:28] == COND_NV) begin
      dec.illegal = 1'b1;
    end
  end

  assign new_e = '{dec: dec, pc: bus.in_pc, tgt: tgt};

  assign acc = bus.in_valid && in_ready_q;
  assign pop = (state_q != ST_EMPTY) && bus.out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (bus.flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            head_d  = new_e;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (acc && pop) begin
            head_d = new_e;
          end else if (acc) begin
            skid_d  = new_e;
            state_d = ST_FULL;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            head_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    in_ready_d = state_d != ST_FULL;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_EMPTY;
      head_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign bus.in_ready          = in_ready_q;
  assign bus.out_valid         = state_q != ST_EMPTY;
  assign bus.out_rn            = head_q.dec.rn;
  assign bus.out_rd            = head_q.dec.rd;
  assign bus.out_rm            = head_q.dec.rm;
  assign bus.out_alu_op        = head_q.dec.alu_op;
  assign bus.out_imm           = head_q.dec.imm;
  assign bus.out_use_imm       = head_q.dec.use_imm;
  assign bus.out_set_flags     = head_q.dec.set_flags;
  assign bus.out_rf_we         = head_q.dec.rf_we;
  assign bus.out_is_branch     = head_q.dec.is_branch;
  assign bus.out_is_link       = head_q.dec.is_link;
  assign bus.out_cond_pass     = head_q.dec.cond_pass;
  assign bus.out_illegal       = head_q.dec.illegal;
  assign bus.out_branch_target = head_q.tgt;
  assign bus.out_pc            = head_q.pc;

endmodule
